// File: rtl/inst_fetch.sv
// Instruction fetch controller for the IF stage: bus read issue, wait-state and flush handling.
// Optional one-entry skid buffer enabled by defining IF_SKID_BUF_EN.
module inst_fetch #(
  parameter logic [31:0] ERR_INST = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_reg,
  input  logic        flush,
  output logic        fetch_stall,
  output logic [31:0] ibus_address,
  output logic        ibus_read,
  input  logic        ibus_stall,
  input  logic [31:0] ibus_rddata,
  input  logic        id_stall,
  output logic        if_valid,
  output logic [31:0] if_inst,
  output logic [31:0] if_pc,
  output logic        if_exc_adel
);

  typedef enum logic {
    FETCH = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] req_addr;
  logic        pend;
  logic        pend_nxt;
  logic        room;
  logic        aligned;
  logic        new_v;
  logic [31:0] new_inst;
  logic        new_adel;

`ifdef IF_SKID_BUF_EN
  logic        skid_valid;
  logic [31:0] skid_inst;
  logic [31:0] skid_pc;
  logic        skid_adel;

  assign room = !skid_valid || !id_stall;
`else
  assign room = !(if_valid && id_stall);
`endif

  assign aligned = (pc_reg[1:0] == 2'b00);

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_nxt;
  end

  // Next state, bus request, stall and the candidate IF/ID entry for this cycle.
  always_comb begin
    state_nxt    = state;
    ibus_read    = 1'b0;
    ibus_address = pc_reg;
    fetch_stall  = 1'b0;
    pend_nxt     = 1'b0;
    new_v        = 1'b0;
    new_inst     = ibus_rddata;
    new_adel     = 1'b0;
    case (state)
      FETCH: begin
        if (flush) begin
          // A read stalled last cycle may not be withdrawn; finish it in DRAIN.
          if (pend) begin
            ibus_read    = 1'b1;
            ibus_address = req_addr;
            if (ibus_stall) state_nxt = DRAIN;
          end
        end else begin
          ibus_read   = room && aligned;
          fetch_stall = (ibus_read && ibus_stall) || !room;
          pend_nxt    = ibus_read && ibus_stall;
          if (ibus_read && !ibus_stall) begin
            new_v = 1'b1;
          end else if (room && !aligned) begin
            new_v    = 1'b1;
            new_inst = ERR_INST;
            new_adel = 1'b1;
          end
        end
      end
      DRAIN: begin
        ibus_read    = 1'b1;
        ibus_address = req_addr;
        fetch_stall  = !flush;
        if (!ibus_stall) state_nxt = FETCH;
      end
      default: state_nxt = FETCH;
    endcase
    if (rst) begin
      state_nxt    = FETCH;
      ibus_read    = 1'b0;
      ibus_address = 32'h0;
      fetch_stall  = 1'b0;
      pend_nxt     = 1'b0;
      new_v        = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr <= 32'h0;
      pend     <= 1'b0;
    end else begin
      pend <= pend_nxt;
      if (state == FETCH && !flush && ibus_read) req_addr <= pc_reg;
    end
  end

`ifdef IF_SKID_BUF_EN
  // IF/ID register plus skid: the skid only fills while ID holds a live entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid    <= 1'b0;
      if_inst     <= 32'h0;
      if_pc       <= 32'h0;
      if_exc_adel <= 1'b0;
      skid_valid  <= 1'b0;
      skid_inst   <= 32'h0;
      skid_pc     <= 32'h0;
      skid_adel   <= 1'b0;
    end else if (flush) begin
      if_valid    <= 1'b0;
      if_exc_adel <= 1'b0;
      skid_valid  <= 1'b0;
    end else if (skid_valid && !id_stall) begin
      if_valid    <= 1'b1;
      if_inst     <= skid_inst;
      if_pc       <= skid_pc;
      if_exc_adel <= skid_adel;
      skid_valid  <= new_v;
      if (new_v) begin
        skid_inst <= new_inst;
        skid_pc   <= pc_reg;
        skid_adel <= new_adel;
      end
    end else if (!if_valid || !id_stall) begin
      if_valid <= new_v;
      if (new_v) begin
        if_inst     <= new_inst;
        if_pc       <= pc_reg;
        if_exc_adel <= new_adel;
      end
    end else if (new_v) begin
      skid_valid <= 1'b1;
      skid_inst  <= new_inst;
      skid_pc    <= pc_reg;
      skid_adel  <= new_adel;
    end
  end
`else
  // IF/ID register: loads when free, holds while ID stalls on a live entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_valid    <= 1'b0;
      if_inst     <= 32'h0;
      if_pc       <= 32'h0;
      if_exc_adel <= 1'b0;
    end else if (flush) begin
      if_valid    <= 1'b0;
      if_exc_adel <= 1'b0;
    end else if (!if_valid || !id_stall) begin
      if_valid <= new_v;
      if (new_v) begin
        if_inst     <= new_inst;
        if_pc       <= pc_reg;
        if_exc_adel <= new_adel;
      end
    end
  end
`endif

endmodule

// File: tb/tb_inst_fetch.sv
// Self-checking bench for inst_fetch: directed vector table then randomized run against a queue model.
module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_reg;
  logic        flush;
  logic        fetch_stall;
  logic [31:0] ibus_address;
  logic        ibus_read;
  logic        ibus_stall;
  logic [31:0] ibus_rddata;
  logic        id_stall;
  logic        if_valid;
  logic [31:0] if_inst;
  logic [31:0] if_pc;
  logic        if_exc_adel;

  int n_vec = 0;
  int n_bad = 0;

`ifdef IF_SKID_BUF_EN
  localparam int unsigned CAP = 2;
`else
  localparam int unsigned CAP = 1;
`endif

  inst_fetch dut (
    .clk(clk), .rst(rst), .pc_reg(pc_reg), .flush(flush),
    .fetch_stall(fetch_stall), .ibus_address(ibus_address), .ibus_read(ibus_read),
    .ibus_stall(ibus_stall), .ibus_rddata(ibus_rddata), .id_stall(id_stall),
    .if_valid(if_valid), .if_inst(if_inst), .if_pc(if_pc), .if_exc_adel(if_exc_adel)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        fl;
    logic        ist;
    logic [31:0] rd;
    logic        ids;
    logic        fs;
    logic        rq;
    logic [31:0] addr;
    logic        v;
    logic [31:0] inst;
    logic [31:0] ipc;
    logic        adel;
    logic        all;
  } vec_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        adel;
  } item_t;

  vec_t  vecs[$];
  item_t mq[$];
  logic        m_drain;
  logic        m_pend;
  logic [31:0] m_req;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic r, input logic [31:0] pc, input logic fl, input logic ist,
                     input logic [31:0] rd, input logic ids, input logic fs, input logic rq,
                     input logic [31:0] addr, input logic v, input logic [31:0] inst,
                     input logic [31:0] ipc, input logic adel, input logic all);
    vec_t t;
    t.rst = r; t.pc = pc; t.fl = fl; t.ist = ist; t.rd = rd; t.ids = ids;
    t.fs = fs; t.rq = rq; t.addr = addr; t.v = v; t.inst = inst; t.ipc = ipc;
    t.adel = adel; t.all = all;
    vecs.push_back(t);
  endtask

  function automatic logic [31:0] dw(input int n);
    return 32'h2400_0000 | 32'(n);
  endfunction

  task automatic build_table();
    add(1, 32'hbfc00000, 0, 0, 0,     0, 0, 0, 0,            0, 0,     0,            0, 1);
    add(0, 32'hbfc00000, 0, 0, dw(0), 0, 0, 1, 32'hbfc00000, 0, 0,     0,            0, 0);
    add(0, 32'hbfc00004, 0, 0, dw(1), 0, 0, 1, 32'hbfc00004, 1, dw(0), 32'hbfc00000, 0, 0);
    add(0, 32'hbfc00008, 0, 0, dw(2), 0, 0, 1, 32'hbfc00008, 1, dw(1), 32'hbfc00004, 0, 0);
    add(0, 32'hbfc0000c, 0, 1, 0,     0, 1, 1, 32'hbfc0000c, 1, dw(2), 32'hbfc00008, 0, 0);
    add(0, 32'hbfc0000c, 0, 1, 0,     0, 1, 1, 32'hbfc0000c, 0, 0,     0,            0, 0);
    add(0, 32'hbfc0000c, 0, 1, 0,     0, 1, 1, 32'hbfc0000c, 0, 0,     0,            0, 0);
    add(0, 32'hbfc0000c, 0, 0, dw(3), 0, 0, 1, 32'hbfc0000c, 0, 0,     0,            0, 0);
    add(0, 32'hbfc00010, 0, 0, dw(4), 0, 0, 1, 32'hbfc00010, 1, dw(3), 32'hbfc0000c, 0, 0);
    add(0, 32'hbfc00012, 0, 0, 0,     0, 0, 0, 0,            1, dw(4), 32'hbfc00010, 0, 0);
    add(0, 32'hbfc00014, 0, 0, dw(5), 0, 0, 1, 32'hbfc00014, 1, 0,     32'hbfc00012, 1, 0);
    add(0, 32'hbfc00018, 0, 1, 0,     0, 1, 1, 32'hbfc00018, 1, dw(5), 32'hbfc00014, 0, 0);
    add(0, 32'hbfc00018, 1, 1, 0,     0, 0, 1, 32'hbfc00018, 0, 0,     0,            0, 0);
    add(0, 32'hbfc00380, 0, 1, 0,     0, 1, 1, 32'hbfc00018, 0, 0,     0,            0, 0);
    add(0, 32'hbfc00380, 0, 0, dw(6), 0, 1, 1, 32'hbfc00018, 0, 0,     0,            0, 0);
    add(0, 32'hbfc00380, 0, 0, dw(7), 0, 0, 1, 32'hbfc00380, 0, 0,     0,            0, 0);
    add(0, 32'hbfc00384, 0, 0, dw(8), 0, 0, 1, 32'hbfc00384, 1, dw(7), 32'hbfc00380, 0, 0);
`ifdef IF_SKID_BUF_EN
    add(0, 32'hbfc00388, 0, 0, dw(9), 1, 0, 1, 32'hbfc00388, 1, dw(8), 32'hbfc00384, 0, 0);
    add(0, 32'hbfc0038c, 0, 0, 0,     1, 1, 0, 0,            1, dw(8), 32'hbfc00384, 0, 0);
    add(0, 32'hbfc0038c, 0, 0, dw(10),0, 0, 1, 32'hbfc0038c, 1, dw(8), 32'hbfc00384, 0, 0);
    add(0, 32'hbfc00390, 0, 0, dw(11),0, 0, 1, 32'hbfc00390, 1, dw(9), 32'hbfc00388, 0, 0);
`else
    add(0, 32'hbfc00388, 0, 0, dw(9), 1, 1, 0, 0,            1, dw(8), 32'hbfc00384, 0, 0);
    add(0, 32'hbfc00388, 0, 0, 0,     1, 1, 0, 0,            1, dw(8), 32'hbfc00384, 0, 0);
    add(0, 32'hbfc00388, 0, 0, dw(9), 0, 0, 1, 32'hbfc00388, 1, dw(8), 32'hbfc00384, 0, 0);
    add(0, 32'hbfc0038c, 0, 0, dw(10),0, 0, 1, 32'hbfc0038c, 1, dw(9), 32'hbfc00388, 0, 0);
`endif
    add(1, 32'hbfc00000, 0, 0, 0,     0, 0, 0, 0,            1, dw(10),32'hbfc0038c, 0, 0);
    add(0, 32'hbfc00400, 0, 0, dw(12),0, 0, 1, 32'hbfc00400, 0, 0,     0,            0, 0);
    add(0, 32'hbfc00404, 0, 1, 0,     0, 1, 1, 32'hbfc00404, 1, dw(12),32'hbfc00400, 0, 0);
    add(0, 32'hbfc00404, 1, 0, dw(13),0, 0, 1, 32'hbfc00404, 0, 0,     0,            0, 0);
    add(0, 32'hbfc00380, 0, 0, dw(14),0, 0, 1, 32'hbfc00380, 0, 0,     0,            0, 0);
    add(0, 32'hbfc00384, 1, 0, 0,     0, 0, 0, 0,            1, dw(14),32'hbfc00380, 0, 0);
    add(0, 32'hbfc00380, 0, 0, dw(15),0, 0, 1, 32'hbfc00380, 0, 0,     0,            0, 0);
    add(0, 32'hbfc00384, 0, 0, dw(16),0, 0, 1, 32'hbfc00384, 1, dw(15),32'hbfc00380, 0, 0);
  endtask

  task automatic drive(input logic r, input logic [31:0] pc, input logic fl, input logic ist,
                       input logic [31:0] rd, input logic ids);
    rst = r; pc_reg = pc; flush = fl; ibus_stall = ist; ibus_rddata = rd; id_stall = ids;
  endtask

  // Expected comb outputs from the model's occupancy and bus bookkeeping.
  task automatic model_comb(output logic fs, output logic rq, output logic [31:0] addr);
    logic room;
    room = (mq.size() < CAP) || !id_stall;
    fs = 1'b0; rq = 1'b0; addr = pc_reg;
    if (rst) begin
      fs = 1'b0; rq = 1'b0;
    end else if (m_drain) begin
      rq = 1'b1; addr = m_req; fs = !flush;
    end else if (flush) begin
      rq = m_pend; addr = m_req;
    end else begin
      rq = room && (pc_reg[1:0] == 2'b00);
      fs = (rq && ibus_stall) || !room;
    end
  endtask

  task automatic model_step(input logic rq);
    item_t it;
    logic  room;
    room = (mq.size() < CAP) || !id_stall;
    if (rst) begin
      mq.delete(); m_drain = 0; m_pend = 0; m_req = 0;
    end else if (m_drain) begin
      if (!ibus_stall) m_drain = 0;
      if (flush) mq.delete();
      m_pend = 0;
    end else if (flush) begin
      mq.delete();
      if (rq && ibus_stall) m_drain = 1;
      m_pend = 0;
    end else begin
      if (!id_stall && mq.size() > 0) void'(mq.pop_front());
      if (rq && !ibus_stall) begin
        it.inst = ibus_rddata; it.pc = pc_reg; it.adel = 0; mq.push_back(it);
      end else if (room && pc_reg[1:0] != 2'b00) begin
        it.inst = 32'h0; it.pc = pc_reg; it.adel = 1; mq.push_back(it);
      end
      m_pend = rq && ibus_stall;
      if (rq) m_req = pc_reg;
    end
  endtask

  initial begin
    logic        e_fs;
    logic        e_rq;
    logic [31:0] e_addr;
    logic [31:0] cur_pc;

    drive(1, 32'hbfc00000, 0, 0, 0, 0);
    repeat (2) @(posedge clk);

    build_table();
    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].pc, vecs[i].fl, vecs[i].ist, vecs[i].rd, vecs[i].ids);
      #1;
      check($sformatf("row%0d fetch_stall", i), 32'(fetch_stall), 32'(vecs[i].fs));
      check($sformatf("row%0d ibus_read", i), 32'(ibus_read), 32'(vecs[i].rq));
      if (vecs[i].rq) check($sformatf("row%0d ibus_address", i), ibus_address, vecs[i].addr);
      if (vecs[i].rst) check($sformatf("row%0d rst ibus_address", i), ibus_address, 32'h0);
      check($sformatf("row%0d if_valid", i), 32'(if_valid), 32'(vecs[i].v));
      if (vecs[i].v || vecs[i].all) begin
        check($sformatf("row%0d if_inst", i), if_inst, vecs[i].inst);
        check($sformatf("row%0d if_pc", i), if_pc, vecs[i].ipc);
        check($sformatf("row%0d if_exc_adel", i), 32'(if_exc_adel), 32'(vecs[i].adel));
      end
    end

    // Randomized run against the queue model, starting from reset.
    @(negedge clk);
    drive(1, 32'hbfc00000, 0, 0, 0, 0);
    @(posedge clk);
    mq.delete(); m_drain = 0; m_pend = 0; m_req = 0;
    cur_pc = 32'hbfc00000;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      drive(($urandom % 100) == 0, cur_pc, ($urandom % 16) == 0, ($urandom % 10) < 3,
            $urandom, ($urandom % 10) < 3);
      #1;
      model_comb(e_fs, e_rq, e_addr);
      check("rnd fetch_stall", 32'(fetch_stall), 32'(e_fs));
      check("rnd ibus_read", 32'(ibus_read), 32'(e_rq));
      if (e_rq) check("rnd ibus_address", ibus_address, e_addr);
      check("rnd if_valid", 32'(if_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("rnd if_inst", if_inst, mq[0].inst);
        check("rnd if_pc", if_pc, mq[0].pc);
        check("rnd if_exc_adel", 32'(if_exc_adel), 32'(mq[0].adel));
      end
      @(posedge clk);
      model_step(e_rq);
      if (rst) cur_pc = 32'hbfc00000;
      else if (flush) cur_pc = 32'hbfc00380;
      else if (!e_fs) begin
        if (($urandom % 20) == 0) cur_pc = $urandom & 32'hffff_fffe;
        else cur_pc = (cur_pc & 32'hffff_fffc) + 32'd4;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
